// File: rtl/vec_mac_engine.sv
// vec_mac_engine: LANES-wide dot-product engine over two internal operand vectors A and B.
// Optional macro VMAC_SIGNED_EN selects two's-complement operands; default build is unsigned.
module vec_mac_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LANES  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          index,
    input  logic [DATA_W-1:0]          a_data,
    input  logic [DATA_W-1:0]          b_data,
    input  logic [31:0]                n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [2*DATA_W+ADDR_W-1:0] result
);
    localparam int ACC_W = 2*DATA_W + ADDR_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
`ifdef VMAC_SIGNED_EN
        logic signed [2*DATA_W-1:0] sx;
        logic signed [2*DATA_W-1:0] sy;
        logic signed [2*DATA_W-1:0] p;
        sx = {{DATA_W{x[DATA_W-1]}}, x};
        sy = {{DATA_W{y[DATA_W-1]}}, y};
        p  = sx * sy;
        return {{ADDR_W{p[2*DATA_W-1]}}, p};
`else
        logic [2*DATA_W-1:0] p;
        p = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        return {{ADDR_W{1'b0}}, p};
`endif
    endfunction

    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic [CW-1:0]     n_eff_q, n_eff_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [1:0]        drain_q, drain_d;

    logic              vld_p0_q, vld_p0_d;
    logic [DATA_W-1:0] rd_a_p0_q [LANES];
    logic [DATA_W-1:0] rd_a_p0_d [LANES];
    logic [DATA_W-1:0] rd_b_p0_q [LANES];
    logic [DATA_W-1:0] rd_b_p0_d [LANES];
    logic              vld_p1_q, vld_p1_d;
    logic [ACC_W-1:0]  prod_p1_q [LANES];
    logic [ACC_W-1:0]  prod_p1_d [LANES];
    logic [ACC_W-1:0]  acc_p2_q, acc_p2_d;
    logic [ACC_W-1:0]  tree_sum;

    logic              mem_wr;
    logic [CW-1:0]     n_clamp;

    assign mem_wr  = we && !busy_q;
    assign n_clamp = (n > 32'(DEPTH)) ? CW'(DEPTH) : n[CW-1:0];

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_a_q[index] <= a_data;
            mem_b_q[index] <= b_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        n_eff_d  = n_eff_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        tree_sum = '0;

        // Stage p0: operand read; lanes at or beyond n_eff read as zero
        vld_p0_d = (state_q == S_RUN);
        for (int l = 0; l < LANES; l++) begin
            if (vld_p0_d && ((idx_q + CW'(l)) < n_eff_q)) begin
                rd_a_p0_d[l] = mem_a_q[idx_q[ADDR_W-1:0] + ADDR_W'(l)];
                rd_b_p0_d[l] = mem_b_q[idx_q[ADDR_W-1:0] + ADDR_W'(l)];
            end else begin
                rd_a_p0_d[l] = '0;
                rd_b_p0_d[l] = '0;
            end
        end

        // Stage p1: per-lane products, already extended to ACC_W
        vld_p1_d = vld_p0_q;
        for (int l = 0; l < LANES; l++) begin
            prod_p1_d[l] = mul_ext(rd_a_p0_q[l], rd_b_p0_q[l]);
        end

        // Stage p2: adder tree into the accumulator
        for (int l = 0; l < LANES; l++) begin
            tree_sum = tree_sum + prod_p1_q[l];
        end
        acc_p2_d = vld_p1_q ? (acc_p2_q + tree_sum) : acc_p2_q;

        case (state_q)
            S_IDLE: begin
                // busy_q still set here means this is the done cycle
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    busy_d   = 1'b1;
                    n_eff_d  = n_clamp;
                    idx_d    = '0;
                    drain_d  = '0;
                    acc_p2_d = '0;
                    state_d  = (n_clamp == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                idx_d = idx_q + CW'(LANES);
                if ((idx_q + CW'(LANES)) >= n_eff_q) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    result_d = acc_p2_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            n_eff_q   <= '0;
            idx_q     <= '0;
            drain_q   <= '0;
            vld_p0_q  <= 1'b0;
            rd_a_p0_q <= '{default: '0};
            rd_b_p0_q <= '{default: '0};
            vld_p1_q  <= 1'b0;
            prod_p1_q <= '{default: '0};
            acc_p2_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            n_eff_q   <= n_eff_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            vld_p0_q  <= vld_p0_d;
            rd_a_p0_q <= rd_a_p0_d;
            rd_b_p0_q <= rd_b_p0_d;
            vld_p1_q  <= vld_p1_d;
            prod_p1_q <= prod_p1_d;
            acc_p2_q  <= acc_p2_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
